// File: rtl/sync_fifo_memory.sv
// Single-clock FIFO with registered read data and occupancy/error flags.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            asynchronous active-high reset
//   write          write request, sampled on the rising edge
//   read           read request, sampled on the rising edge
//   data_in        write data, captured on an accepted write
//   data_out       registered read data, holds when no read is accepted
//   fifo_full      occupancy == DEPTH
//   fifo_empty     occupancy == 0
//   fifo_overflow  one-cycle pulse after a rejected write
//   fifo_underflow one-cycle pulse after a rejected read
module sync_fifo_memory #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam logic [ADDR_WIDTH:0]   FullCount = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CountOne  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_ok;
    logic rd_ok;

    assign fifo_full      = (count_q == FullCount);
    assign fifo_empty     = (count_q == '0);
    assign data_out       = data_out_q;
    assign fifo_overflow  = overflow_q;
    assign fifo_underflow = underflow_q;

    // A write into a full FIFO is still fine if a read frees a slot on the same edge.
    assign rd_ok = read && !fifo_empty;
    assign wr_ok = write && (!fifo_full || rd_ok);

    always_comb begin
        write_addr_d = write_addr_q;
        read_addr_d  = read_addr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        overflow_d   = write && !wr_ok;
        underflow_d  = read && !rd_ok;

        if (wr_ok) begin
            write_addr_d = write_addr_q + AddrOne;
        end
        if (rd_ok) begin
            // Reads the old contents; a same-edge write to this slot lands afterwards.
            data_out_d  = mem[read_addr_q];
            read_addr_d = read_addr_q + AddrOne;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_addr_q <= '0;
            read_addr_q  <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            write_addr_q <= write_addr_d;
            read_addr_q  <= read_addr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is not reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[write_addr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_memory.sv
module tb_sync_fifo_memory;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       read;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_overflow;
    logic       fifo_underflow;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo_memory #(
        .DATA_WIDTH(8),
        .DEPTH     (8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write         (write),
        .read          (read),
        .data_in       (data_in),
        .data_out      (data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_overflow (fifo_overflow),
        .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests; return 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        #1;
        write   = 1'b0;
        read    = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic chk_flags(input string tag, input logic full, input logic empty,
                             input logic ovf, input logic udf);
        chk({tag, "_full"}, {7'd0, fifo_full}, {7'd0, full});
        chk({tag, "_empty"}, {7'd0, fifo_empty}, {7'd0, empty});
        chk({tag, "_ovf"}, {7'd0, fifo_overflow}, {7'd0, ovf});
        chk({tag, "_udf"}, {7'd0, fifo_underflow}, {7'd0, udf});
    endtask

    initial begin
        logic [7:0] stream [7];
        stream = '{8'h54, 8'hFF, 8'hE0, 8'hD1, 8'h7C, 8'h09, 8'hB6};

        rst = 1'b1; write = 1'b0; read = 1'b0; data_in = 8'h00;
        #1;
        chk("rst_dout", data_out, 8'h00);
        chk_flags("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming: one write, then concurrent read+write
        step(1'b1, 1'b0, 8'hEA);
        chk_flags("s_first", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s_first_dout", data_out, 8'h00);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, stream[i]);
            chk("s_dout", data_out, (i == 0) ? 8'hEA : stream[i-1]);
            chk("s_empty", {7'd0, fifo_empty}, 8'h00);
        end
        step(1'b0, 1'b1, 8'h00);
        chk("s_last_dout", data_out, 8'hB6);
        chk_flags("s_end", 1'b0, 1'b1, 1'b0, 1'b0);

        // Fill to full, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk("f_full", {7'd0, fifo_full}, (i == 8) ? 8'h01 : 8'h00);
        end
        step(1'b1, 1'b0, 8'hAA);
        chk_flags("f_ovf", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk_flags("f_ovf_clr", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("f_dout", data_out, 8'(i));
        end
        chk_flags("f_drained", 1'b0, 1'b1, 1'b0, 1'b0);

        // Pointer wrap: move pointers to 5, then 8 entries across 7->0
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("w_pre_dout", data_out, 8'hA0 + 8'(i));
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        chk_flags("w_full", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("w_dout", data_out, 8'h10 + 8'(i));
        end
        chk_flags("w_end", 1'b0, 1'b1, 1'b0, 1'b0);

        // Underflow, then read+write while empty
        step(1'b0, 1'b1, 8'h00);
        chk_flags("u_pulse", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("u_hold", data_out, 8'h17);
        step(1'b0, 1'b0, 8'h00);
        chk_flags("u_clr", 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h3C);
        chk_flags("u_rw", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("u_rw_hold", data_out, 8'h17);
        step(1'b0, 1'b1, 8'h00);
        chk("u_rw_dout", data_out, 8'h3C);
        chk_flags("u_rw_end", 1'b0, 1'b1, 1'b0, 1'b0);

        // Full with concurrent read+write
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h61 + 8'(i));
        chk_flags("fr_full", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h99);
        chk_flags("fr_rw", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fr_rw_dout", data_out, 8'h61);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("fr_dout", data_out, 8'h61 + 8'(i));
        end
        step(1'b0, 1'b1, 8'h00);
        chk("fr_last", data_out, 8'h99);
        chk_flags("fr_end", 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-operation
        step(1'b1, 1'b0, 8'h55);
        step(1'b0, 1'b1, 8'h00);
        chk("a_dout_pre", data_out, 8'h55);
        step(1'b1, 1'b0, 8'h66);
        chk("a_empty_pre", {7'd0, fifo_empty}, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("a_dout", data_out, 8'h00);
        chk_flags("a_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        chk_flags("a_discard", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("a_discard_dout", data_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
